// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for the multi-cycle ALU enable/busy port.
// One operation is taken per request handshake. The operands are registered,
// the ALU is enabled for exactly one cycle, and the result and compare flags
// are captured when busy drops. They are returned on a valid/ready response
// channel together with the request tag.
// Optional build macro: ALUSEQ_WATCHDOG_EN adds a WAIT-state watchdog. When it
// expires, the watchdog resets the ALU and returns an error response.
module alu_op_sequencer #(
    parameter int TAG_W      = 4,
    parameter int WDOG_LIMIT = 64
) (
    input  logic             I_clk,
    input  logic             I_reset,
    // request channel
    input  logic             I_req_valid,
    output logic             O_req_ready,
    input  logic [4:0]       I_req_op,
    input  logic [31:0]      I_req_a,
    input  logic [31:0]      I_req_b,
    input  logic [TAG_W-1:0] I_req_tag,
    // response channel
    output logic             O_rsp_valid,
    input  logic             I_rsp_ready,
    output logic [31:0]      O_rsp_data,
    output logic             O_rsp_lt,
    output logic             O_rsp_ltu,
    output logic             O_rsp_eq,
    output logic [TAG_W-1:0] O_rsp_tag,
    output logic             O_rsp_err,
    // ALU port
    output logic             O_alu_en,
    output logic [4:0]       O_alu_op,
    output logic [31:0]      O_alu_s1,
    output logic [31:0]      O_alu_s2,
    output logic             O_alu_reset,
    input  logic             I_alu_busy,
    input  logic [31:0]      I_alu_data,
    input  logic             I_alu_lt,
    input  logic             I_alu_ltu,
    input  logic             I_alu_eq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [TAG_W-1:0]   r_tag;

    logic [31:0]        r_rsp_data;
    logic               r_rsp_lt;
    logic               r_rsp_ltu;
    logic               r_rsp_eq;

    logic               w_req_hs;
    logic               w_capture;
    logic               w_wdog_trip;

    assign w_req_hs  = (r_state == ST_IDLE) && I_req_valid;
    assign w_capture = (r_state == ST_WAIT) && !I_alu_busy;

`ifdef ALUSEQ_WATCHDOG_EN
    localparam logic [15:0] LP_WDOG_LIMIT = 16'(WDOG_LIMIT);

    logic [15:0]        r_wdog_cnt;
    logic               r_wdog_pulse;
    logic               r_rsp_err;

    // The watchdog trips on the busy WAIT cycle that brings the count up to the limit.
    assign w_wdog_trip = (r_state == ST_WAIT) && I_alu_busy &&
                         (r_wdog_cnt == (LP_WDOG_LIMIT - 16'd1));

    // Watchdog counter: cleared on ISSUE, counts busy WAIT cycles
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_wdog_cnt <= 16'd0;
        end else if (r_state == ST_ISSUE) begin
            r_wdog_cnt <= 16'd0;
        end else if ((r_state == ST_WAIT) && I_alu_busy) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end else begin
            r_wdog_cnt <= r_wdog_cnt;
        end
    end

    // One-cycle ALU reset pulse registered from the watchdog trip
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_wdog_pulse <= 1'b0;
        end else begin
            r_wdog_pulse <= w_wdog_trip;
        end
    end

    // Error flag: set by an aborted WAIT, cleared by a normal completion
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= 1'b0;
        end else if (w_wdog_trip) begin
            r_rsp_err <= 1'b1;
        end else begin
            r_rsp_err <= r_rsp_err;
        end
    end

    assign O_alu_reset = I_reset | r_wdog_pulse;
    assign O_rsp_err   = r_rsp_err;
`else
    logic w_unused_wdog;

    // Without the watchdog, WAIT lasts until busy drops.
    assign w_wdog_trip   = 1'b0;
    assign w_unused_wdog = |WDOG_LIMIT;
    assign O_alu_reset   = I_reset;
    assign O_rsp_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_req_valid) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!I_alu_busy) begin
                    w_state_nxt = ST_RESP;
                end else if (w_wdog_trip) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (I_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State-decoded handshake and enable outputs. Enable is never raised in WAIT.
    // Raising it there would restart the ALU when busy falls.
    always_comb begin
        O_req_ready = 1'b0;
        O_rsp_valid = 1'b0;
        O_alu_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                O_req_ready = 1'b1;
            end
            ST_ISSUE: begin
                O_alu_en = 1'b1;
            end
            ST_WAIT: begin
                O_alu_en = 1'b0;
            end
            ST_RESP: begin
                O_rsp_valid = 1'b1;
            end
            default: begin
                O_req_ready = 1'b0;
            end
        endcase
    end

    // Operand registers: loaded only on the request handshake.
    // They stay frozen until the next operation, because the ALU re-reads them late.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_op  <= 5'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_tag <= '0;
        end else if (w_req_hs) begin
            r_op  <= I_req_op;
            r_a   <= I_req_a;
            r_b   <= I_req_b;
            r_tag <= I_req_tag;
        end else begin
            r_op  <= r_op;
            r_a   <= r_a;
            r_b   <= r_b;
            r_tag <= r_tag;
        end
    end

    // Response capture: the ALU result on the first non-busy WAIT cycle, zeros on abort
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_rsp_data <= 32'd0;
            r_rsp_lt   <= 1'b0;
            r_rsp_ltu  <= 1'b0;
            r_rsp_eq   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= I_alu_data;
            r_rsp_lt   <= I_alu_lt;
            r_rsp_ltu  <= I_alu_ltu;
            r_rsp_eq   <= I_alu_eq;
        end else if (w_wdog_trip) begin
            r_rsp_data <= 32'd0;
            r_rsp_lt   <= 1'b0;
            r_rsp_ltu  <= 1'b0;
            r_rsp_eq   <= 1'b0;
        end else begin
            r_rsp_data <= r_rsp_data;
            r_rsp_lt   <= r_rsp_lt;
            r_rsp_ltu  <= r_rsp_ltu;
            r_rsp_eq   <= r_rsp_eq;
        end
    end

    assign O_alu_op   = r_op;
    assign O_alu_s1   = r_a;
    assign O_alu_s2   = r_b;
    assign O_rsp_data = r_rsp_data;
    assign O_rsp_lt   = r_rsp_lt;
    assign O_rsp_ltu  = r_rsp_ltu;
    assign O_rsp_eq   = r_rsp_eq;
    assign O_rsp_tag  = r_tag;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
// A behavioural ALU stub sits on the ALU port. It computes its result from the
// sequencer's ALU outputs at finalisation time. A driver pushes hand-computed
// expectations into a queue, and a negedge monitor pops them on each response
// handshake and compares.
module tb_alu_op_sequencer;

    localparam int TAG_W = 4;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SLL  = 5'd1;
    localparam logic [4:0] OP_SLT  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REM  = 5'd18;

    logic             I_clk = 1'b0;
    logic             I_reset = 1'b1;
    logic             I_req_valid = 1'b0;
    logic             O_req_ready;
    logic [4:0]       I_req_op = 5'd0;
    logic [31:0]      I_req_a = 32'd0;
    logic [31:0]      I_req_b = 32'd0;
    logic [TAG_W-1:0] I_req_tag = '0;
    logic             O_rsp_valid;
    logic             I_rsp_ready = 1'b0;
    logic [31:0]      O_rsp_data;
    logic             O_rsp_lt, O_rsp_ltu, O_rsp_eq;
    logic [TAG_W-1:0] O_rsp_tag;
    logic             O_rsp_err;
    logic             O_alu_en;
    logic [4:0]       O_alu_op;
    logic [31:0]      O_alu_s1, O_alu_s2;
    logic             O_alu_reset;
    logic             I_alu_busy = 1'b0;
    logic [31:0]      I_alu_data;
    logic             I_alu_lt, I_alu_ltu, I_alu_eq;

    alu_op_sequencer #(.TAG_W(TAG_W), .WDOG_LIMIT(8)) dut (
        .I_clk(I_clk), .I_reset(I_reset),
        .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_op(I_req_op), .I_req_a(I_req_a), .I_req_b(I_req_b), .I_req_tag(I_req_tag),
        .O_rsp_valid(O_rsp_valid), .I_rsp_ready(I_rsp_ready),
        .O_rsp_data(O_rsp_data), .O_rsp_lt(O_rsp_lt), .O_rsp_ltu(O_rsp_ltu),
        .O_rsp_eq(O_rsp_eq), .O_rsp_tag(O_rsp_tag), .O_rsp_err(O_rsp_err),
        .O_alu_en(O_alu_en), .O_alu_op(O_alu_op), .O_alu_s1(O_alu_s1), .O_alu_s2(O_alu_s2),
        .O_alu_reset(O_alu_reset), .I_alu_busy(I_alu_busy), .I_alu_data(I_alu_data),
        .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq)
    );

    always #5 I_clk = ~I_clk;

    int unsigned cyc = 0;
    always @(posedge I_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ALU stub ----------------
    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  alu_model = a + b;
            OP_SLL:  alu_model = a << b[4:0];
            OP_SLT:  alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_DIV:  alu_model = (b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
            OP_DIVU: alu_model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  alu_model = (b == 32'd0) ? a : 32'($signed(a) % $signed(b));
            default: alu_model = 32'd0;
        endcase
    endfunction

    int   stub_lat   = 0;
    logic stub_stuck = 1'b0;
    int   busy_left  = 0;

    always @(posedge I_clk or posedge O_alu_reset) begin
        if (O_alu_reset) begin
            I_alu_busy <= 1'b0;
            busy_left  <= 0;
        end else if (O_alu_en) begin
            if (stub_stuck) begin
                I_alu_busy <= 1'b1;
            end else if (stub_lat > 0) begin
                I_alu_busy <= 1'b1;
                busy_left  <= stub_lat;
            end
        end else if (I_alu_busy && !stub_stuck) begin
            if (busy_left <= 1) I_alu_busy <= 1'b0;
            busy_left <= busy_left - 1;
        end
    end

    always_comb begin
        I_alu_data = I_alu_busy ? 32'hDEAD_BEEF : alu_model(O_alu_op, O_alu_s1, O_alu_s2);
        I_alu_lt   = $signed(O_alu_s1) < $signed(O_alu_s2);
        I_alu_ltu  = O_alu_s1 < O_alu_s2;
        I_alu_eq   = O_alu_s1 == O_alu_s2;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0]      data;
        logic             lt, ltu, eq, err;
        logic [TAG_W-1:0] tag;
        int unsigned      hs;
        int               lat;
    } exp_t;
    exp_t sb_q[$];

    int          stall_req  = 0;
    int          stall_left = 0;
    logic        prev_valid = 1'b0;
    int unsigned first_v    = 0;
    int unsigned en_cyc     = 0;
    int          en_cnt     = 0;
    int          viol       = 0;
    int          rst_pulses = 0;
    logic [68:0] snap       = '0;

    // Monitor: tracks enable pulses and operand stability, and compares responses.
    always @(negedge I_clk) begin
        exp_t e;
        if (I_reset) begin
            en_cnt      = 0;
            viol        = 0;
            prev_valid  = 1'b0;
            I_rsp_ready = 1'b0;
        end else begin
            if (O_alu_en) begin
                en_cnt++;
                en_cyc = cyc;
                snap   = {O_alu_op, O_alu_s1, O_alu_s2};
            end
            if (I_alu_busy && ({O_alu_op, O_alu_s1, O_alu_s2} != snap)) viol++;
            if (O_alu_reset) rst_pulses++;
            if (O_rsp_valid) begin
                if (!prev_valid) begin
                    first_v    = cyc;
                    stall_left = stall_req;
                end
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                    I_rsp_ready = 1'b1;
                end else if (stall_left > 0) begin
                    I_rsp_ready = 1'b0;
                    chk("stall_req_ready", {31'd0, O_req_ready}, 32'd0);
                    chk("stall_data_held", O_rsp_data, sb_q[0].data);
                    stall_left--;
                end else begin
                    I_rsp_ready = 1'b1;
                    e = sb_q.pop_front();
                    chk("rsp_data", O_rsp_data, e.data);
                    chk("rsp_lt",   {31'd0, O_rsp_lt},  {31'd0, e.lt});
                    chk("rsp_ltu",  {31'd0, O_rsp_ltu}, {31'd0, e.ltu});
                    chk("rsp_eq",   {31'd0, O_rsp_eq},  {31'd0, e.eq});
                    chk("rsp_tag",  32'(O_rsp_tag), 32'(e.tag));
                    chk("rsp_err",  {31'd0, O_rsp_err}, {31'd0, e.err});
                    chk("alu_en_pulses", 32'(en_cnt), 32'd1);
                    chk("en_cycle", en_cyc - e.hs, 32'd1);
                    chk("operands_stable", 32'(viol), 32'd0);
                    if (e.lat > 0) chk("rsp_latency", first_v - e.hs, 32'(e.lat));
                    en_cnt = 0;
                    viol   = 0;
                end
            end else begin
                I_rsp_ready = 1'b0;
            end
            prev_valid = O_rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int lat, input int stall,
                         input logic [31:0] ed, input logic elt, input logic eltu,
                         input logic eeq, input logic eerr, input int elat);
        exp_t e;
        int n;
        stub_lat  = lat;
        stall_req = stall;
        @(negedge I_clk);
        I_req_valid = 1'b1;
        I_req_op    = op;
        I_req_a     = a;
        I_req_b     = b;
        I_req_tag   = tag;
        n = 0;
        while (!O_req_ready && n < 200) begin
            @(negedge I_clk);
            n++;
        end
        chk("req_accept", {31'd0, O_req_ready}, 32'd1);
        e.data = ed; e.lt = elt; e.ltu = eltu; e.eq = eeq; e.err = eerr;
        e.tag = tag; e.hs = cyc; e.lat = elat;
        sb_q.push_back(e);
        @(negedge I_clk);
        // These values must be ignored once the request is taken.
        I_req_valid = 1'b0;
        I_req_op    = 5'h1F;
        I_req_a     = 32'hA5A5_0000;
        I_req_b     = 32'h0000_5A5A;
        I_req_tag   = ~tag;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge I_clk);
            n++;
        end
        chk("rsp_timeout", 32'(sb_q.size()), 32'd0);
        stall_req = 0;
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("reset_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
        chk("reset_alu_en",    {31'd0, O_alu_en},    32'd0);
        chk("reset_alu_op",    32'(O_alu_op),        32'd0);
        chk("reset_alu_s1",    O_alu_s1,             32'd0);
        chk("reset_rsp_data",  O_rsp_data,           32'd0);
        chk("reset_alu_reset", {31'd0, O_alu_reset}, 32'd1);
        @(negedge I_clk);
        #2 I_reset = 1'b0;

        //     op       a             b             tag   lat st  data           lt    ltu   eq    err   latency
        issue(OP_ADD,  32'd5,        32'd7,        4'd3, 0,  0,  32'd12,        1'b1, 1'b1, 1'b0, 1'b0, 3);
        issue(OP_SLL,  32'd1,        32'd31,       4'd5, 6,  0,  32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        issue(OP_DIV,  32'd100,      32'd7,        4'd6, 33, 0,  32'd14,        1'b0, 1'b0, 1'b0, 1'b0, 0);
        issue(OP_REM,  32'd100,      32'd7,        4'd7, 33, 0,  32'd2,         1'b0, 1'b0, 1'b0, 1'b0, 0);
        issue(OP_DIVU, 32'd42,       32'd0,        4'd8, 0,  0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'd1,       4'hA, 0,  5,  32'd1,         1'b1, 1'b0, 1'b0, 1'b0, 3);

        // Reset in the middle of a long DIV
        stub_lat = 33;
        @(negedge I_clk);
        I_req_valid = 1'b1; I_req_op = OP_DIV; I_req_a = 32'd100; I_req_b = 32'd7; I_req_tag = 4'hC;
        n = 0;
        while (!O_req_ready && n < 200) begin
            @(negedge I_clk);
            n++;
        end
        @(negedge I_clk);
        I_req_valid = 1'b0;
        repeat (5) @(negedge I_clk);
        chk("mid_div_busy", {31'd0, I_alu_busy}, 32'd1);
        #2 I_reset = 1'b1;
        #1;
        chk("async_rst_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
        chk("async_rst_alu_en",    {31'd0, O_alu_en},    32'd0);
        chk("async_rst_alu_op",    32'(O_alu_op),        32'd0);
        chk("async_rst_alu_s1",    O_alu_s1,             32'd0);
        chk("async_rst_alu_s2",    O_alu_s2,             32'd0);
        chk("async_rst_rsp_data",  O_rsp_data,           32'd0);
        chk("async_rst_rsp_tag",   32'(O_rsp_tag),       32'd0);
        chk("async_rst_alu_reset", {31'd0, O_alu_reset}, 32'd1);
        chk("async_rst_busy",      {31'd0, I_alu_busy},  32'd0);
        @(negedge I_clk);
        @(negedge I_clk);
        #2 I_reset = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 4'd1, 0, 0, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3);

`ifdef ALUSEQ_WATCHDOG_EN
        // Busy stuck high: the watchdog must abort the operation with an error response
        stub_stuck = 1'b1;
        rst_pulses = 0;
        issue(OP_ADD, 32'd2, 32'd3, 4'd9, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        chk("wdog_reset_pulses", 32'(rst_pulses), 32'd1);
        stub_stuck = 1'b0;
        issue(OP_ADD, 32'd4, 32'd4, 4'd2, 0, 0, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, 3);
`endif

        repeat (3) @(negedge I_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
